// File: rtl/fir_hb39_serial_sched.sv
`default_nettype none
// ============================================================================
// Module   : fir_hb39_serial_sched
// Purpose  : Time-multiplexed 39-tap symmetric half-band FIR. A single shared
//            multiplier/accumulator walks the nine non-zero symmetric
//            coefficient pairs plus the centre tap, one term per cycle.
// Ports    : clock, reset        - rising-edge clock, sync active-high reset
//            in_valid/in_ready   - sample handshake, in_data unsigned W bits
//            out_valid/out_ready - result handshake, out_data unsigned AW bits
//                                  (normalised value = out_data >> 12)
//            busy                - high while a sample is in flight
// Revision : 1.0 - initial release
// ============================================================================
module fir_hb39_serial_sched #(
  parameter int W  = 12,
  parameter int CW = 11,
  parameter int AW = W + 12
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_data,
  output logic          busy
);

  localparam int PW = W + CW + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    MAC  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t        state;
  logic [3:0]    k;
  logic [AW-1:0] acc;
  logic [W-1:0]  x [0:38];

  logic [W:0]    pair_sum;
  logic [CW-1:0] coef;
  logic [PW-1:0] prod;
  logic [AW-1:0] acc_next;

  // Term selection for step k: outer pair first, centre tap last.
  always_comb begin
    pair_sum = '0;
    coef     = '0;
    case (k)
      4'd0: begin pair_sum = {1'b0, x[2]}  + {1'b0, x[36]}; coef = CW'(2);    end
      4'd1: begin pair_sum = {1'b0, x[4]}  + {1'b0, x[34]}; coef = CW'(5);    end
      4'd2: begin pair_sum = {1'b0, x[6]}  + {1'b0, x[32]}; coef = CW'(11);   end
      4'd3: begin pair_sum = {1'b0, x[8]}  + {1'b0, x[30]}; coef = CW'(23);   end
      4'd4: begin pair_sum = {1'b0, x[10]} + {1'b0, x[28]}; coef = CW'(43);   end
      4'd5: begin pair_sum = {1'b0, x[12]} + {1'b0, x[26]}; coef = CW'(76);   end
      4'd6: begin pair_sum = {1'b0, x[14]} + {1'b0, x[24]}; coef = CW'(133);  end
      4'd7: begin pair_sum = {1'b0, x[16]} + {1'b0, x[22]}; coef = CW'(258);  end
      4'd8: begin pair_sum = {1'b0, x[18]} + {1'b0, x[20]}; coef = CW'(835);  end
      4'd9: begin pair_sum = {1'b0, x[19]};                 coef = CW'(1324); end
      default: begin pair_sum = '0; coef = '0; end
    endcase
  end

  assign prod     = PW'(pair_sum) * PW'(coef);
  assign acc_next = acc + AW'(prod);

  // Gated by reset so the source never sees a handshake during the reset cycle.
  assign in_ready = (state == IDLE) && !reset;
  assign busy     = (state != IDLE);

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      k         <= '0;
      acc       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      for (int i = 0; i < 39; i++) x[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            for (int i = 38; i > 0; i--) x[i] <= x[i-1];
            x[0]  <= in_data;
            acc   <= '0;
            k     <= '0;
            state <= LOAD;
          end
        end
        LOAD: begin
          state <= MAC;
        end
        MAC: begin
          acc <= acc_next;
          if (k == 4'd9) begin
            out_data  <= acc_next;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            k <= k + 4'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fir_hb39_serial_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_fir_hb39_serial_sched
// Purpose  : Self-checking bench for fir_hb39_serial_sched. Expected outputs
//            come from a direct convolution of the full 39-tap coefficient
//            set against a queue of accepted samples.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fir_hb39_serial_sched;

  localparam int W  = 12;
  localparam int CW = 11;
  localparam int AW = W + 12;

  logic          clock = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_data;
  logic          busy;

  fir_hb39_serial_sched #(.W(W), .CW(CW), .AW(AW)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int passes = 0;

  longint  h_tab [0:38];
  longint  hist [$];
  longint  cyc = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  function automatic longint model_out();
    longint s = 0;
    for (int i = 0; i < hist.size(); i++) s += h_tab[i] * hist[i];
    return s;
  endfunction

  task automatic model_push(input longint v);
    hist.push_front(v);
    if (hist.size() > 39) void'(hist.pop_back());
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Present one sample, wait for acceptance, then wait for the result and
  // optionally stall the consumer before taking it.
  task automatic run_sample(input logic [W-1:0] v, input int stall, input string tag);
    int n;
    in_data  = v;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin step(); n++; end
    if (n >= 50) check({tag, "_accept_timeout"}, 0, 1);
    step();
    in_valid = 1'b0;
    model_push(longint'(v));
    n = 0;
    while (!out_valid && n < 50) begin step(); n++; end
    if (n >= 50) check({tag, "_valid_timeout"}, 0, 1);
    repeat (stall) step();
    check(tag, 32'(out_data), 32'(model_out()));
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    hist.delete();
  endtask

  initial begin
    int  t_acc [$];
    int  n;
    bit  ok_ready, ok_valid, ok_stable;
    logic [AW-1:0] held;

    for (int i = 0; i < 39; i++) h_tab[i] = 0;
    h_tab[2] = 2;    h_tab[4] = 5;    h_tab[6] = 11;   h_tab[8] = 23;
    h_tab[10] = 43;  h_tab[12] = 76;  h_tab[14] = 133; h_tab[16] = 258;
    h_tab[18] = 835; h_tab[19] = 1324;
    for (int i = 0; i < 19; i++) h_tab[38-i] = h_tab[i];

    reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    step(); step();
    // Reset-state values while reset is still asserted.
    check("rst_in_ready",  32'(in_ready),  0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_data",  32'(out_data),  0);
    check("rst_busy",      32'(busy),      0);
    reset = 1'b0;
    #1;
    check("idle_in_ready", 32'(in_ready), 1);

    // Impulse response: outputs trace the coefficient set.
    for (int i = 0; i < 39; i++) begin
      run_sample((i == 0) ? 12'd1 : 12'd0, 0, "impulse");
      if (i == 19) check("impulse_centre", 32'(out_data), 1324);
    end

    // Step of ones, then full-scale step.
    for (int i = 0; i < 40; i++) run_sample(12'd1, 0, "step1");
    check("step1_final", 32'(out_data), 4096);
    for (int i = 0; i < 40; i++) run_sample(12'd4095, 0, "step_max");
    check("step_max_final", 32'(out_data), 16773120);

    // Randomized samples with random consumer stalls.
    for (int i = 0; i < 50; i++)
      run_sample(12'($urandom_range(0, 4095)), int'($urandom_range(0, 3)), "random");

    // Timing of a single accepted sample.
    in_data = 12'($urandom_range(0, 4095));
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    model_push(longint'(in_data));
    ok_ready = 1'b1; ok_valid = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      if (in_ready !== 1'b0) ok_ready = 1'b0;
      if (c < 12 && out_valid !== 1'b0) ok_valid = 1'b0;
      if (c == 12 && out_valid !== 1'b1) ok_valid = 1'b0;
      if (c < 12) step();
    end
    check("timing_in_ready_low", 32'(ok_ready), 1);
    check("timing_out_valid_t12", 32'(ok_valid), 1);
    check("timing_result", 32'(out_data), 32'(model_out()));
    out_ready = 1'b1;
    step();

    // Back-to-back accepts with the consumer always ready.
    in_valid = 1'b1;
    n = 0;
    while (t_acc.size() < 4 && n < 100) begin
      in_data = 12'($urandom_range(0, 4095));
      @(negedge clock);
      if (in_ready) begin
        t_acc.push_back(int'(cyc));
        model_push(longint'(in_data));
      end
      @(posedge clock);
      #1;
      n++;
    end
    in_valid = 1'b0;
    if (t_acc.size() < 4) check("b2b_timeout", 0, 1);
    for (int i = 1; i < t_acc.size(); i++)
      check("b2b_spacing", 32'(t_acc[i] - t_acc[i-1]), 13);
    n = 0;
    while (!out_valid && n < 50) begin step(); n++; end
    check("b2b_last_result", 32'(out_data), 32'(model_out()));
    step();
    out_ready = 1'b0;

    // Backpressure: result held for 20 cycles while a new sample waits.
    in_data = 12'd777;
    in_valid = 1'b1;
    step();
    model_push(777);
    in_data = 12'd1234;
    n = 0;
    while (!out_valid && n < 50) begin step(); n++; end
    held = out_data;
    check("bp_result", 32'(held), 32'(model_out()));
    ok_valid = 1'b1; ok_stable = 1'b1; ok_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      step();
      if (out_valid !== 1'b1) ok_valid = 1'b0;
      if (out_data !== held) ok_stable = 1'b0;
      if (in_ready !== 1'b0) ok_ready = 1'b0;
    end
    check("bp_valid_held", 32'(ok_valid), 1);
    check("bp_data_stable", 32'(ok_stable), 1);
    check("bp_in_ready_low", 32'(ok_ready), 1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("bp_release_ready", 32'(in_ready), 1);
    step();
    in_valid = 1'b0;
    model_push(1234);
    n = 0;
    while (!out_valid && n < 50) begin step(); n++; end
    check("bp_pending_result", 32'(out_data), 32'(model_out()));
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // Reset during MAC step k=5 after non-zero history.
    in_data = 12'd3000;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (6) step();
    do_reset();
    ok_valid = 1'b1;
    for (int c = 0; c < 15; c++) begin
      if (out_valid !== 1'b0) ok_valid = 1'b0;
      step();
    end
    check("midrst_no_valid", 32'(ok_valid), 1);
    check("midrst_busy", 32'(busy), 0);
    for (int i = 0; i < 21; i++)
      run_sample((i == 0) ? 12'd1 : 12'd0, 0, "midrst_impulse");
    check("midrst_impulse_tap20", 32'(out_data), 835);

    // Symmetry: x[2]=3, x[36]=7.
    do_reset();
    run_sample(12'd7, 0, "sym_pair");
    for (int i = 0; i < 33; i++) run_sample(12'd0, 0, "sym_pair");
    run_sample(12'd3, 0, "sym_pair");
    run_sample(12'd0, 0, "sym_pair");
    run_sample(12'd0, 0, "sym_pair");
    check("sym_pair_value", 32'(out_data), 20);

    // Centre only: x[19]=1.
    do_reset();
    run_sample(12'd1, 0, "sym_centre");
    for (int i = 0; i < 19; i++) run_sample(12'd0, 0, "sym_centre");
    check("sym_centre_value", 32'(out_data), 1324);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=%0d expected=0", cyc);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/fir_hb39_serial_sched.md
Name: fir_hb39_serial_sched

Overview:
- Time-multiplexed scheduler for the team's 39-tap symmetric half-band binary FIR.
- Owns a 39-entry sample delay line and one shared multiplier/accumulator. It sequences the nine non-zero symmetric coefficient pairs and the centre tap over successive cycles.
- Sits between the sample source and the downstream consumer. Valid/ready handshake on both sides.
- Replaces the fully parallel 10-multiplier datapath where area matters more than throughput.

Parameters:
- W, 12, unsigned input sample width.
- CW, 11, coefficient width (must hold 1324).
- AW, W+12, output/accumulator width. Coefficient sum = 4096, so full precision needs no overflow handling.

Ports:
- clock  in  1  sampling/system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  sample available.
- in_ready  out  1  scheduler can accept a sample.
- in_data  in  W  unsigned input sample.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- out_data  out  AW  unsigned full-precision filter output. Normalised value = out_data >> 12.
- busy  out  1  high in LOAD/MAC/DONE.

Behaviour:
- Delay line x[0..38]:
  - x[0] is the newest sample and x[i] is the sample i accepts ago.
  - All entries reset to 0.
- Coefficients h[i] (constant ROM, symmetric h[i] = h[38-i]):
  - Non-zero values: h2=2, h4=5, h6=11, h8=23, h10=43, h12=76, h14=133, h16=258, h18=835, h19=1324. Mirrors h20..h36 are equal to these.
  - All other taps are 0 and are never scheduled.
- Arithmetic:
  - Unsigned throughout.
  - Pair sum x[i]+x[38-i] is W+1 bits.
  - Product is W+1+CW bits, zero-extended into the AW accumulator. No truncation or saturation.
- FSM states: IDLE, LOAD, MAC, DONE. Reset enters IDLE.
  - IDLE: in_ready=1. On in_valid: shift delay line (x[i] <= x[i-1], x[0] <= in_data), clear acc, clear step counter k, go to LOAD.
  - LOAD: one cycle, pipeline alignment only. Go to MAC.
  - MAC: exactly one accumulate per cycle, 10 cycles total.
    - k=0..8: acc += h[2k+2]*(x[2k+2]+x[36-2k]).
    - k=9: acc += h19*x[19].
    - After k=9, latch out_data <= final acc and go to DONE.
  - DONE: out_valid=1, out_data stable. On out_ready, go to IDLE.
- Latency and throughput:
  - Accept edge at cycle T; out_valid rises at cycle T+12.
  - At most one sample in flight. in_ready=0 from LOAD through DONE.
  - Maximum throughput is one sample per 13 cycles with out_ready tied high.
- Backpressure: out_ready low in DONE holds out_valid=1 and out_data unchanged indefinitely. No new sample is accepted.
- Reset values: in_ready=0 during the reset cycle and 1 in IDLE afterwards. out_valid=0, out_data=0, busy=0, acc=0, k=0.
- Reset mid-operation (any state): abort the computation, clear the delay line, drop out_valid the next cycle, return to IDLE. No partial result is emitted.
- in_valid outside IDLE is ignored. The sample is not consumed, and the source must hold it.
- out_data changes only on entry to DONE.

Test Plan:
- Impulse: after reset, feed 1 then 38 zeros, out_ready=1 → 39 outputs equal to h[0..38] in order: 0,0,2,0,5,0,11,…,835,1324,835,…,2,0,0.
- Step: feed 39+ samples of value 1 → outputs ramp by cumulative h and reach steady 4096. Feed 4095 (W=12) → steady 16773120 with no overflow.
- Timing/handshake: single sample accepted at cycle T → in_ready low at T+1..T+12, out_valid first high at T+12. Back-to-back in_valid=1 → accepts spaced exactly 13 cycles apart.
- Backpressure: hold out_ready=0 for 20 cycles in DONE → out_valid stays 1, out_data constant, in_ready stays 0, and the pending input is not consumed. Release → in_ready=1 the next cycle.
- Reset mid-MAC: assert reset at k=5 after loading non-zero history → no out_valid. Next impulse input reproduces the clean impulse response, proving the delay line was cleared.
- Symmetry check: load x[2]=3 and x[36]=7 with all others 0 → out_data = 2*(3+7) = 20. Load x[19]=1 only → 1324.
